// File: rtl/piano_sequencer.sv
// piano_sequencer: autoplay controller for the eight-key piano tone generator.
// Steps through a song ROM and drives one-hot note selects for the programmed
// number of beats, with a silent gap after each note. A single-key manual
// press always overrides the sequencer on the output.
//
// Song contents come from the SONG_DATA parameter. Entry i occupies bits
// [8*i+7:8*i]. Entry format is [7] rest, [6:4] note, [3:0] beats, and
// 0 beats marks the end of the song.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_play         start request, acts only when idle
//   i_stop         abort request, acts in any state and wins over i_play
//   i_loop         restart from entry 0 at end of song
//   i_manual_keys  player keys, bit i = note i
//   o_keys         one-hot (or zero) note select to the piano, combinational
//   o_busy         high in every state except idle
//   o_pos          index of the current ROM entry
module piano_sequencer #(
  parameter int unsigned   BEAT_TICKS = 12500000,
  parameter int unsigned   GAP_TICKS  = 1250000,
  parameter int unsigned   SONG_LEN   = 32,
  parameter logic [2047:0] SONG_DATA  = {1920'h0,
    128'h00_81_44_32_22_44_32_22_02_22_12_02_02_22_12_02}
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_play,
  input  logic                        i_stop,
  input  logic                        i_loop,
  input  logic [7:0]                  i_manual_keys,
  output logic [7:0]                  o_keys,
  output logic                        o_busy,
  output logic [$clog2(SONG_LEN)-1:0] o_pos
);

  localparam int unsigned PW       = $clog2(SONG_LEN);
  localparam int unsigned TICK_MAX = (BEAT_TICKS > GAP_TICKS) ? BEAT_TICKS : GAP_TICKS;
  localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NOTE,
    S_GAP,
    S_ADVANCE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pos;
  logic [TW-1:0]   r_tick;
  logic [3:0]      r_beat;
  logic [7:0]      r_seq_keys;
  logic            r_busy;

  logic [7:0]      w_entry;
  logic            w_last;
  logic            w_manual_onehot;

  // ROM read of the current entry
  always_comb begin
    w_entry = 8'h00;
    for (int i = 0; i < int'(SONG_LEN); i++) begin
      if (r_pos == PW'(i)) w_entry = SONG_DATA[8*i +: 8];
    end
  end

  assign w_last = (r_pos == PW'(SONG_LEN - 1));

  // Manual press counts only when exactly one key is down
  assign w_manual_onehot = (i_manual_keys != 8'h00) &&
                           ((i_manual_keys & (i_manual_keys - 8'd1)) == 8'h00);

  assign o_keys = w_manual_onehot ? i_manual_keys : r_seq_keys;
  assign o_busy = r_busy;
  assign o_pos  = r_pos;

  // Sequencer FSM with registered pos/keys/busy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pos      <= '0;
      r_tick     <= '0;
      r_beat     <= 4'd0;
      r_seq_keys <= 8'h00;
      r_busy     <= 1'b0;
    end else if (i_stop) begin
      r_state    <= S_IDLE;
      r_pos      <= '0;
      r_seq_keys <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_play) begin
            r_state <= S_LOAD;
            r_pos   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_entry[3:0] != 4'd0) begin
            r_beat     <= w_entry[3:0];
            r_tick     <= '0;
            r_seq_keys <= w_entry[7] ? 8'h00 : (8'h01 << w_entry[6:4]);
            r_state    <= S_NOTE;
          end else if (i_loop && (r_pos != '0)) begin
            // An empty entry 0 would loop forever, so only loop from later entries
            r_pos   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_pos   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_NOTE: begin
          if (r_tick == TW'(BEAT_TICKS - 1)) begin
            r_tick <= '0;
            if (r_beat == 4'd1) begin
              r_beat     <= 4'd0;
              r_seq_keys <= 8'h00;
              r_state    <= (GAP_TICKS == 0) ? S_ADVANCE : S_GAP;
            end else begin
              r_beat <= r_beat - 4'd1;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        S_GAP: begin
          if (r_tick == TW'(GAP_LAST)) begin
            r_tick  <= '0;
            r_state <= S_ADVANCE;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        S_ADVANCE: begin
          if (!w_last) begin
            r_pos   <= r_pos + PW'(1);
            r_state <= S_LOAD;
          end else if (i_loop) begin
            r_pos   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_pos   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_seq_keys <= 8'h00;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piano_sequencer.sv
// Directed bench for piano_sequencer: 4-tick beats, 2-tick gap, 4-entry song
// {0x02, 0x41, 0x81, 0x00}. A second instance holds an empty song (entry 0 = 0x00).
module tb_piano_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       play, stop, loop, play_b;
  logic [7:0] manual, manual_b;
  logic [7:0] keys, keys_b;
  logic       busy, busy_b;
  logic [1:0] pos, pos_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piano_sequencer #(
    .BEAT_TICKS(4), .GAP_TICKS(2), .SONG_LEN(4),
    .SONG_DATA({2016'h0, 32'h00_81_41_02})
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_play(play), .i_stop(stop), .i_loop(loop),
    .i_manual_keys(manual), .o_keys(keys), .o_busy(busy), .o_pos(pos)
  );

  piano_sequencer #(
    .BEAT_TICKS(4), .GAP_TICKS(2), .SONG_LEN(4),
    .SONG_DATA({2016'h0, 32'h00_81_41_00})
  ) u_dut_empty (
    .i_clk(clk), .i_rst(rst), .i_play(play_b), .i_stop(stop), .i_loop(loop),
    .i_manual_keys(manual_b), .o_keys(keys_b), .o_busy(busy_b), .o_pos(pos_b)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0; play_b = 1'b0;
    manual = 8'h00; manual_b = 8'h00;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_keys", keys, 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_pos", 8'(pos), 8'h00);

    // Full song, no loop; play sampled at edge 0
    play = 1'b1; step(1); play = 1'b0;
    chk("e0_busy", 8'(busy), 8'h01);
    chk("e0_keys", keys, 8'h00);
    step(1);  chk("e1_keys", keys, 8'h01);
    step(7);  chk("e8_keys", keys, 8'h01);
    step(1);  chk("e9_gap_keys", keys, 8'h00);
              chk("e9_busy", 8'(busy), 8'h01);
    step(2);  chk("e11_adv_pos", 8'(pos), 8'h00);
    step(1);  chk("e12_load_pos", 8'(pos), 8'h01);
    step(1);  chk("e13_keys", keys, 8'h10);
    step(3);  chk("e16_keys", keys, 8'h10);
    step(1);  chk("e17_keys", keys, 8'h00);
    step(3);  chk("e20_pos", 8'(pos), 8'h02);
    step(1);  chk("e21_rest_keys", keys, 8'h00);
    step(7);  chk("e28_pos", 8'(pos), 8'h03);
              chk("e28_busy", 8'(busy), 8'h01);
    step(1);  chk("e29_busy", 8'(busy), 8'h00);
              chk("e29_pos", 8'(pos), 8'h00);
              chk("e29_keys", keys, 8'h00);

    // Loop: wraps back to entry 0 without dropping busy
    loop = 1'b1;
    play = 1'b1; step(1); play = 1'b0;
    step(28); chk("loop_e28_pos", 8'(pos), 8'h03);
    step(1);  chk("loop_e29_pos", 8'(pos), 8'h00);
              chk("loop_e29_busy", 8'(busy), 8'h01);
    step(1);  chk("loop_e30_keys", keys, 8'h01);
    step(4);  chk("loop_beat2_keys", keys, 8'h01);

    // Stop during second beat of entry 0
    stop = 1'b1; step(1); stop = 1'b0; loop = 1'b0;
    chk("stop_keys", keys, 8'h00);
    chk("stop_busy", 8'(busy), 8'h00);
    chk("stop_pos", 8'(pos), 8'h00);

    // Fresh play, manual override, play while busy
    play = 1'b1; step(1); play = 1'b0;
    chk("rp_busy", 8'(busy), 8'h01);
    chk("rp_pos", 8'(pos), 8'h00);
    step(1);  chk("rp_keys", keys, 8'h01);
    manual = 8'h08; step(1); chk("man_08", keys, 8'h08);
    manual = 8'h00; step(1); chk("man_release", keys, 8'h01);
    manual = 8'h0C; step(1); chk("man_multi", keys, 8'h01);
    manual = 8'h00;
    play = 1'b1; step(1); play = 1'b0;
    chk("pbusy_pos", 8'(pos), 8'h00);
    chk("pbusy_keys", keys, 8'h01);
    step(8);  chk("pbusy_e13_keys", keys, 8'h10);
              chk("pbusy_e13_pos", 8'(pos), 8'h01);
    step(16); chk("pbusy_end_busy", 8'(busy), 8'h00);

    // play and stop together from idle
    play = 1'b1; stop = 1'b1; step(1); play = 1'b0; stop = 1'b0;
    chk("ps_busy", 8'(busy), 8'h00);
    step(1);  chk("ps_busy2", 8'(busy), 8'h00);

    // Manual pass-through while idle
    manual = 8'h04; step(1); chk("idle_man_04", keys, 8'h04);
    manual = 8'h03; step(1); chk("idle_man_03", keys, 8'h00);
    manual = 8'h00;

    // Reset mid-note
    play = 1'b1; step(1); play = 1'b0;
    step(2);  chk("rmid_keys_pre", keys, 8'h01);
    rst = 1'b1; step(1);
    chk("rmid_keys", keys, 8'h00);
    chk("rmid_busy", 8'(busy), 8'h00);
    chk("rmid_pos", 8'(pos), 8'h00);
    rst = 1'b0; step(1);
    chk("rmid_busy2", 8'(busy), 8'h00);

    // Empty song with loop set: LOAD then back to idle
    loop = 1'b1;
    play_b = 1'b1; step(1); play_b = 1'b0;
    chk("empty_busy_load", 8'(busy_b), 8'h01);
    chk("empty_keys", keys_b, 8'h00);
    step(1);  chk("empty_busy_idle", 8'(busy_b), 8'h00);
              chk("empty_pos", 8'(pos_b), 8'h00);
    step(3);  chk("empty_busy_stays", 8'(busy_b), 8'h00);
    loop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
